// File: rtl/wb_bridge64to128.sv
// Wishbone 64-bit initiator to 128-bit responder bridge: registered request path,
// in-order lane FIFO for steering 128-bit read data back onto the 64-bit bus.
package wb_bridge_pkg;
  localparam logic [2:0] SZ_HEXI = 3'd4;

  typedef struct packed {
    logic [1:0]  om;
    logic [4:0]  cmd;
    logic [3:0]  cid;
    logic [7:0]  tid;
    logic [1:0]  bte;
    logic [5:0]  blen;
    logic [2:0]  cti;
    logic [1:0]  seg;
    logic [2:0]  sz;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [7:0]  sel;
    logic [7:0]  asid;
    logic [31:0] vadr;
    logic [31:0] padr;
    logic [7:0]  pl;
    logic [3:0]  pri;
    logic [3:0]  cache;
    logic        csr;
    logic [63:0] dat;
  } wb_cmd_request64_t;

  typedef struct packed {
    logic [1:0]   om;
    logic [4:0]   cmd;
    logic [3:0]   cid;
    logic [7:0]   tid;
    logic [1:0]   bte;
    logic [5:0]   blen;
    logic [2:0]   cti;
    logic [1:0]   seg;
    logic [2:0]   sz;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [7:0]   asid;
    logic [31:0]  vadr;
    logic [31:0]  padr;
    logic [7:0]   pl;
    logic [3:0]   pri;
    logic [3:0]   cache;
    logic         csr;
    logic [127:0] data1;
  } wb_cmd_request128_t;

  typedef struct packed {
    logic [3:0]  cid;
    logic [7:0]  tid;
    logic        stall;
    logic        next;
    logic        ack;
    logic        rty;
    logic        err;
    logic [3:0]  pri;
    logic [31:0] adr;
    logic [63:0] dat;
  } wb_cmd_response64_t;

  typedef struct packed {
    logic [3:0]   cid;
    logic [7:0]   tid;
    logic         stall;
    logic         next;
    logic         ack;
    logic         rty;
    logic         err;
    logic [3:0]   pri;
    logic [31:0]  adr;
    logic [127:0] dat;
  } wb_cmd_response128_t;
endpackage

module wb_bridge64to128
  import wb_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  wb_cmd_request64_t   req64_i,
  output wb_cmd_response64_t  resp64_o,
  output wb_cmd_request128_t  req128_o,
  input  wb_cmd_response128_t resp128_i
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic       lane;
    logic [7:0] tid;
  } lane_ent_t;

  lane_ent_t          fifo_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count;
  wb_cmd_request128_t req_q, fwd;
  logic               errpend_q;
  logic [7:0]         err_tid_q;

  logic stall, accept, is_hexi, push, pop, resp_any, err_fire, head_lane, beat_held;

  assign beat_held = req_q.stb & resp128_i.stall;
  assign stall     = beat_held | (count == FULL) | errpend_q;
  assign accept    = req64_i.cyc & req64_i.stb & ~stall;
  assign is_hexi   = (req64_i.sz == SZ_HEXI);
  assign push      = accept & ~is_hexi;
  assign resp_any  = resp128_i.ack | resp128_i.err | resp128_i.rty;
  assign pop       = resp_any & (count != '0);
  // The downstream response owns the return bus; the local error waits for a quiet cycle.
  assign err_fire  = errpend_q & ~resp_any;
  assign head_lane = (count != '0) & fifo_q[rd_ptr_q].lane;

  always_comb begin
    fwd       = '0;
    fwd.om    = req64_i.om;
    fwd.cmd   = req64_i.cmd;
    fwd.cid   = req64_i.cid;
    fwd.tid   = req64_i.tid;
    fwd.bte   = req64_i.bte;
    fwd.blen  = req64_i.blen;
    fwd.cti   = req64_i.cti;
    fwd.seg   = req64_i.seg;
    fwd.sz    = req64_i.sz;
    fwd.cyc   = req64_i.cyc;
    fwd.stb   = 1'b1;
    fwd.we    = req64_i.we;
    fwd.sel   = req64_i.padr[3] ? {req64_i.sel, 8'h00} : {8'h00, req64_i.sel};
    fwd.asid  = req64_i.asid;
    fwd.vadr  = req64_i.vadr;
    fwd.padr  = req64_i.padr;
    fwd.pl    = req64_i.pl;
    fwd.pri   = req64_i.pri;
    fwd.cache = req64_i.cache;
    fwd.csr   = req64_i.csr;
    fwd.data1 = {2{req64_i.dat}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= '0;
    end else if (!req64_i.cyc) begin
      req_q.cyc <= 1'b0;
      req_q.stb <= 1'b0;
    end else if (accept) begin
      if (is_hexi) begin
        req_q.cyc <= 1'b1;
        req_q.stb <= 1'b0;
      end else begin
        req_q <= fwd;
      end
    end else if (!beat_held) begin
      req_q.cyc <= 1'b1;
      req_q.stb <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else if (!req64_i.cyc) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= '{lane: req64_i.padr[3], tid: req64_i.tid};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      errpend_q <= 1'b0;
      err_tid_q <= '0;
    end else if (!req64_i.cyc) begin
      errpend_q <= 1'b0;
    end else if (accept && is_hexi) begin
      errpend_q <= 1'b1;
      err_tid_q <= req64_i.tid;
    end else if (err_fire) begin
      errpend_q <= 1'b0;
    end
  end

  assign req128_o = req_q;

  always_comb begin
    resp64_o       = '0;
    resp64_o.cid   = resp128_i.cid;
    resp64_o.tid   = err_fire ? err_tid_q : resp128_i.tid;
    resp64_o.stall = stall;
    resp64_o.next  = resp128_i.next;
    resp64_o.ack   = resp128_i.ack;
    resp64_o.rty   = resp128_i.rty;
    resp64_o.err   = rst_ni & (resp128_i.err | err_fire);
    resp64_o.pri   = resp128_i.pri;
    resp64_o.adr   = resp128_i.adr;
    resp64_o.dat   = head_lane ? resp128_i.dat[127:64] : resp128_i.dat[63:0];
  end
endmodule

// File: tb/tb_wb_bridge64to128.sv
// Self-checking bench for wb_bridge64to128: directed scenarios plus a randomized
// run compared against a transaction-level model (queue of outstanding lanes).
module tb_wb_bridge64to128;
  import wb_bridge_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [63:0] HI = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] LO = 64'h5555_5555_5555_5555;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  wb_cmd_request64_t   req64;
  wb_cmd_response64_t  resp64;
  wb_cmd_request128_t  req128;
  wb_cmd_response128_t resp128;

  int tests_run    = 0;
  int tests_failed = 0;

  wb_cmd_request128_t m_req;
  logic [8:0]         m_q[$];
  logic               m_err;
  logic [7:0]         m_etid;

  always #5 clk_i = ~clk_i;

  wb_bridge64to128 #(.DEPTH(DEPTH)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req64_i   (req64),
    .resp64_o  (resp64),
    .req128_o  (req128),
    .resp128_i (resp128)
  );

  function automatic wb_cmd_request64_t rand_req();
    logic [383:0] bits;
    for (int i = 0; i < 12; i++) bits[i*32 +: 32] = $urandom;
    return wb_cmd_request64_t'(bits[$bits(wb_cmd_request64_t)-1:0]);
  endfunction

  function automatic wb_cmd_response128_t rand_resp();
    logic [383:0] bits;
    for (int i = 0; i < 12; i++) bits[i*32 +: 32] = $urandom;
    return wb_cmd_response128_t'(bits[$bits(wb_cmd_response128_t)-1:0]);
  endfunction

  function automatic wb_cmd_request64_t mk_req(input logic we, input logic lane,
                                               input logic [7:0] tid);
    wb_cmd_request64_t r;
    r         = rand_req();
    r.cyc     = 1'b1;
    r.stb     = 1'b1;
    r.we      = we;
    r.padr[3] = lane;
    r.tid     = tid;
    r.sz      = 3'd3;
    return r;
  endfunction

  function automatic wb_cmd_request128_t exp_fwd(input wb_cmd_request64_t r);
    wb_cmd_request128_t e;
    e = '0;
    e.om = r.om; e.cmd = r.cmd; e.cid = r.cid; e.tid = r.tid; e.bte = r.bte;
    e.blen = r.blen; e.cti = r.cti; e.seg = r.seg; e.sz = r.sz; e.cyc = r.cyc;
    e.we = r.we; e.asid = r.asid; e.vadr = r.vadr; e.padr = r.padr; e.pl = r.pl;
    e.pri = r.pri; e.cache = r.cache; e.csr = r.csr;
    e.stb   = 1'b1;
    e.sel   = r.padr[3] ? {r.sel, 8'h00} : {8'h00, r.sel};
    e.data1 = {r.dat, r.dat};
    return e;
  endfunction

  function automatic logic m_stall();
    return (m_req.stb && resp128.stall) || (m_q.size() == DEPTH) || m_err;
  endfunction

  task automatic model_reset();
    m_req  = '0;
    m_q.delete();
    m_err  = 1'b0;
    m_etid = '0;
  endtask

  // Advance the reference model by one clock edge using the inputs held right now.
  task automatic model_edge();
    logic acc, ra;
    acc = req64.cyc && req64.stb && !m_stall();
    ra  = resp128.ack || resp128.err || resp128.rty;
    if (!rst_ni) begin
      model_reset();
    end else if (!req64.cyc) begin
      m_q.delete();
      m_err     = 1'b0;
      m_req.cyc = 1'b0;
      m_req.stb = 1'b0;
    end else begin
      if (m_err && !ra) m_err = 1'b0;
      if (ra && m_q.size() > 0) void'(m_q.pop_front());
      if (acc && req64.sz == SZ_HEXI) begin
        m_err     = 1'b1;
        m_etid    = req64.tid;
        m_req.cyc = 1'b1;
        m_req.stb = 1'b0;
      end else if (acc) begin
        m_req = exp_fwd(req64);
        m_q.push_back({req64.padr[3], req64.tid});
      end else if (!(m_req.stb && resp128.stall)) begin
        m_req.cyc = 1'b1;
        m_req.stb = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req64   = '0;
    resp128 = '0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    req64       = mk_req(1'b0, 1'b1, 8'h11);
    resp128     = '0;
    resp128.ack = 1'b1;
    resp128.err = 1'b1;
    resp128.dat = {HI, LO};
    #1;
    tests_run++;
    if (req128 !== '0) begin
      tests_failed++;
      $display("FAIL reset_req128 got %h want 0", req128);
    end
    tests_run++;
    if (resp64.stall !== 1'b0 || resp64.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_stall_err got stall=%b err=%b want 0 0", resp64.stall, resp64.err);
    end
    tests_run++;
    if (resp64.ack !== 1'b1 || resp64.dat !== LO) begin
      tests_failed++;
      $display("FAIL reset_passthru got ack=%b dat=%h want 1 %h", resp64.ack, resp64.dat, LO);
    end
    req64   = '0;
    resp128 = '0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    req64      = mk_req(1'b0, 1'b1, 8'h05);
    req64.padr = 32'h0000_1008;
    req64.sel  = 8'h0F;
    #1;
    tests_run++;
    if (resp64.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_stall got %b want 0", resp64.stall);
    end
    tick();
    req64.stb = 1'b0;
    #1;
    tests_run++;
    if (req128.stb !== 1'b1 || req128.sel !== 16'h0F00 || req128.padr !== 32'h0000_1008
        || req128.tid !== 8'h05) begin
      tests_failed++;
      $display("FAIL read_beat got stb=%b sel=%h padr=%h tid=%h want 1 0f00 00001008 05",
               req128.stb, req128.sel, req128.padr, req128.tid);
    end
    tick();
    resp128.ack = 1'b1;
    resp128.tid = 8'h05;
    resp128.dat = {HI, LO};
    #1;
    tests_run++;
    if (resp64.dat !== HI || resp64.ack !== 1'b1 || req128.stb !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_resp got dat=%h ack=%b stb=%b want %h 1 0",
               resp64.dat, resp64.ack, req128.stb, HI);
    end
    tick();
    #1;
    tests_run++;
    if (resp64.dat !== LO) begin
      tests_failed++;
      $display("FAIL empty_resp_lane0 got %h want %h", resp64.dat, LO);
    end
    idle();
  endtask

  task automatic test_write();
    req64     = mk_req(1'b1, 1'b0, 8'h21);
    req64.dat = 64'h0123456789ABCDEF;
    req64.sel = 8'hFF;
    #1;
    tick();
    req64.stb = 1'b0;
    #1;
    tests_run++;
    if (req128.data1 !== 128'h0123456789ABCDEF0123456789ABCDEF || req128.sel !== 16'h00FF
        || req128.we !== 1'b1 || req128.stb !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_beat got data1=%h sel=%h we=%b stb=%b",
               req128.data1, req128.sel, req128.we, req128.stb);
    end
    idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      req64 = mk_req(1'b0, 1'b0, 8'(i));
      #1;
      tests_run++;
      if (resp64.stall !== 1'b0) begin
        tests_failed++;
        $display("FAIL full_fill%0d_stall got %b want 0", i, resp64.stall);
      end
      tick();
    end
    req64 = mk_req(1'b0, 1'b0, 8'h44);
    #1;
    tests_run++;
    if (resp64.stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_stall got %b want 1", resp64.stall);
    end
    tick();
    tests_run++;
    if (resp64.stall !== 1'b1 || req128.stb !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_hold got stall=%b stb=%b want 1 0", resp64.stall, req128.stb);
    end
    resp128.ack = 1'b1;
    #1;
    tick();
    resp128.ack = 1'b0;
    #1;
    tests_run++;
    if (resp64.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_release got %b want 0", resp64.stall);
    end
    tick();
    req64.stb = 1'b0;
    #1;
    tests_run++;
    if (req128.stb !== 1'b1 || req128.tid !== 8'h44 || resp64.stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_fifth got stb=%b tid=%h stall=%b want 1 44 1",
               req128.stb, req128.tid, resp64.stall);
    end
    idle();
  endtask

  task automatic test_stall_hold();
    wb_cmd_request128_t e;
    req64 = mk_req(1'b1, 1'b1, 8'h77);
    e     = exp_fwd(req64);
    #1;
    tick();
    req64.stb     = 1'b0;
    resp128.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (req128 !== e || resp64.stall !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_hold%0d got req=%h stall=%b want req=%h stall=1",
                 i, req128, resp64.stall, e);
      end
      tick();
    end
    resp128.stall = 1'b0;
    #1;
    tests_run++;
    if (req128 !== e || resp64.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_release got stb=%b stall=%b want 1 0", req128.stb, resp64.stall);
    end
    tick();
    tests_run++;
    if (req128.stb !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_done_stb got %b want 0", req128.stb);
    end
    idle();
  endtask

  task automatic test_hexi_err();
    req64 = mk_req(1'b0, 1'b0, 8'h01);
    #1;
    tick();
    req64    = mk_req(1'b0, 1'b1, 8'h3C);
    req64.sz = SZ_HEXI;
    #1;
    tests_run++;
    if (resp64.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL hexi_accept_stall got %b want 0", resp64.stall);
    end
    tick();
    req64.stb   = 1'b0;
    resp128.ack = 1'b1;
    resp128.tid = 8'h01;
    #1;
    tests_run++;
    if (resp64.err !== 1'b0 || resp64.tid !== 8'h01 || resp64.ack !== 1'b1
        || req128.stb !== 1'b0 || resp64.stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL hexi_ack_first got err=%b tid=%h ack=%b stb=%b stall=%b want 0 01 1 0 1",
               resp64.err, resp64.tid, resp64.ack, req128.stb, resp64.stall);
    end
    tick();
    resp128 = '0;
    #1;
    tests_run++;
    if (resp64.err !== 1'b1 || resp64.tid !== 8'h3C || req128.stb !== 1'b0) begin
      tests_failed++;
      $display("FAIL hexi_err got err=%b tid=%h stb=%b want 1 3c 0",
               resp64.err, resp64.tid, req128.stb);
    end
    tick();
    tests_run++;
    if (resp64.err !== 1'b0 || resp64.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL hexi_clear got err=%b stall=%b want 0 0", resp64.err, resp64.stall);
    end
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      req64 = mk_req(1'b0, 1'b1, 8'(8'h50 + i));
      #1;
      tick();
    end
    req64 = '0;
    #1;
    tick();
    resp128.ack = 1'b1;
    resp128.dat = {HI, LO};
    #1;
    tests_run++;
    if (req128.cyc !== 1'b0 || req128.stb !== 1'b0 || resp64.dat !== LO
        || resp64.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush got cyc=%b stb=%b dat=%h stall=%b want 0 0 %h 0",
               req128.cyc, req128.stb, resp64.dat, resp64.stall, LO);
    end
    idle();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      req64 = mk_req(1'b0, 1'b0, 8'(8'h60 + i));
      #1;
      tick();
    end
    req64.stb   = 1'b0;
    resp128.ack = 1'b1;
    resp128.dat = {HI, LO};
    #1;
    rst_ni = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (req128.cyc !== 1'b0 || req128.stb !== 1'b0 || resp64.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset got cyc=%b stb=%b stall=%b want 0 0 0",
               req128.cyc, req128.stb, resp64.stall);
    end
    resp128 = '0;
    tick();
    rst_ni = 1'b1;
    req64  = mk_req(1'b0, 1'b1, 8'h09);
    #1;
    tests_run++;
    if (resp64.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_stall got %b want 0", resp64.stall);
    end
    tick();
    req64.stb = 1'b0;
    #1;
    tick();
    resp128.ack = 1'b1;
    resp128.dat = {HI, LO};
    #1;
    tests_run++;
    if (resp64.dat !== HI) begin
      tests_failed++;
      $display("FAIL post_reset_lane got %h want %h", resp64.dat, HI);
    end
    idle();
  endtask

  task automatic test_random();
    logic             ra, ef, hl;
    logic [63:0]      e_dat;
    logic [7:0]       e_tid;
    int               r;
    rst_ni = 1'b0;
    req64  = '0;
    resp128 = '0;
    tick();
    rst_ni = 1'b1;
    tick();
    for (int c = 0; c < 400; c++) begin
      req64     = rand_req();
      req64.cyc = ($urandom_range(0, 39) != 0);
      req64.stb = $urandom_range(0, 1);
      req64.sz  = ($urandom_range(0, 9) == 0) ? SZ_HEXI : 3'($urandom_range(0, 3));
      resp128       = rand_resp();
      r             = $urandom_range(0, 9);
      resp128.ack   = (r < 3);
      resp128.err   = (r == 3);
      resp128.rty   = (r == 4);
      resp128.stall = ($urandom_range(0, 3) == 0);
      #1;
      ra    = resp128.ack || resp128.err || resp128.rty;
      ef    = m_err && !ra;
      hl    = (m_q.size() > 0) ? m_q[0][8] : 1'b0;
      e_dat = hl ? resp128.dat[127:64] : resp128.dat[63:0];
      e_tid = ef ? m_etid : resp128.tid;
      tests_run++;
      if (req128 !== m_req) begin
        tests_failed++;
        $display("FAIL rand_req128 c=%0d got %h want %h", c, req128, m_req);
      end
      tests_run++;
      if (resp64.stall !== m_stall()) begin
        tests_failed++;
        $display("FAIL rand_stall c=%0d got %b want %b", c, resp64.stall, m_stall());
      end
      tests_run++;
      if (resp64.dat !== e_dat) begin
        tests_failed++;
        $display("FAIL rand_dat c=%0d got %h want %h", c, resp64.dat, e_dat);
      end
      tests_run++;
      if (resp64.err !== (resp128.err || ef) || resp64.tid !== e_tid
          || resp64.ack !== resp128.ack) begin
        tests_failed++;
        $display("FAIL rand_resp c=%0d got err=%b tid=%h ack=%b want %b %h %b", c,
                 resp64.err, resp64.tid, resp64.ack, resp128.err || ef, e_tid, resp128.ack);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst_ni  = 1'b0;
    req64   = '0;
    resp128 = '0;
    model_reset();
    tick();
    test_reset();
    test_single_read();
    test_write();
    test_full();
    test_stall_hold();
    test_hexi_err();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
